// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// The request phase uses req/gnt. The response phase uses rvalid/rdata/err.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: the memory-access stage that follows execute.
// It takes one load or store from EX and runs one req/gnt/rvalid bus transaction.
// The core is stalled until the transaction completes.
// Load data is returned aligned and sign- or zero-extended.
// Misaligned accesses and the invalid type complete without any bus access.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [1:0]             data_type_i,
    input  logic                   data_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    output logic                   stall_o,
    output logic                   resp_valid_o,
    output logic [DATA_WIDTH-1:0]  rdata_o,
    output logic                   err_o,
    load_store_unit_if.master      mem_bus
);

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // A half access needs an even offset. A word access needs offset 0.
    // Type 11 is never accepted onto the bus.
    function automatic logic f_access_ok(input logic [1:0] dtype, input logic [1:0] off);
        logic ok;
        case (dtype)
            DT_BYTE: ok = 1'b1;
            DT_HALF: ok = (off[0] == 1'b0);
            DT_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [3:0] f_byte_enable(input logic [1:0] dtype, input logic [1:0] off);
        logic [3:0] be;
        case (dtype)
            DT_BYTE: be = 4'b0001 << off;
            DT_HALF: be = 4'b0011 << off;
            DT_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes, so every enabled lane sees the right byte.
    function automatic logic [31:0] f_replicate(input logic [1:0] dtype, input logic [31:0] wdata);
        logic [31:0] rep;
        case (dtype)
            DT_BYTE: rep = {4{wdata[7:0]}};
            DT_HALF: rep = {2{wdata[15:0]}};
            DT_WORD: rep = wdata;
            default: rep = 32'h0000_0000;
        endcase
        return rep;
    endfunction

    // Move the addressed bytes down to bit 0, then sign- or zero-extend them.
    function automatic logic [31:0] f_format_load(input logic [31:0] raw,
                                                  input logic [1:0]  off,
                                                  input logic [1:0]  dtype,
                                                  input logic        sext);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (dtype)
            DT_BYTE: res = sext ? {{24{sh[7]}}, sh[7:0]}   : {24'h00_0000, sh[7:0]};
            DT_HALF: res = sext ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            DT_WORD: res = sh;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              type_q, type_d;
    logic                    sign_q, sign_d;
    logic [1:0]              off_q, off_d;
    logic [3:0]              be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept_s;
    logic                    access_ok_s;
    logic                    bus_active_s;

    assign accept_s    = (state_q == ST_IDLE) && data_req_i;
    assign access_ok_s = f_access_ok(data_type_i, addr_i[1:0]);

    // Next-state logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    state_d = access_ok_s ? ST_REQ : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_bus.gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response is accepted only here, so an rvalid that arrives together with gnt is ignored.
                if (mem_bus.rvalid) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                // data_req_i is still high for the retiring instruction, so it is not sampled here.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall and response outputs, decoded from the current state.
    always_comb begin
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        bus_active_s = 1'b0;
        case (state_q)
            ST_IDLE: stall_o = data_req_i && !rst;
            ST_REQ: begin
                stall_o      = 1'b1;
                bus_active_s = 1'b1;
            end
            ST_WAIT: stall_o = 1'b1;
            ST_DONE: resp_valid_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    // Latch the request at accept, and capture the result on the edge that enters DONE.
    always_comb begin
        we_d        = we_q;
        type_d      = type_q;
        sign_d      = sign_q;
        off_d       = off_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        word_addr_d = word_addr_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (accept_s) begin
            we_d        = data_we_i;
            type_d      = data_type_i;
            sign_d      = data_sign_ext_i;
            off_d       = addr_i[1:0];
            be_d        = f_byte_enable(data_type_i, addr_i[1:0]);
            wdata_d     = f_replicate(data_type_i, wdata_i);
            word_addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            if (!access_ok_s) begin
                rdata_d = {DATA_WIDTH{1'b0}};
                err_d   = 1'b1;
            end else begin
                rdata_d = rdata_q;
                err_d   = err_q;
            end
        end else if ((state_q == ST_WAIT) && mem_bus.rvalid) begin
            err_d = mem_bus.err;
            if (we_q || mem_bus.err) begin
                rdata_d = {DATA_WIDTH{1'b0}};
            end else begin
                rdata_d = f_format_load(mem_bus.rdata, off_q, type_q, sign_q);
            end
        end else begin
            rdata_d = rdata_q;
            err_d   = err_q;
        end
    end

    // State and datapath registers. Reset aborts any transaction in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            type_q      <= 2'b00;
            sign_q      <= 1'b0;
            off_q       <= 2'b00;
            be_q        <= 4'b0000;
            wdata_q     <= {DATA_WIDTH{1'b0}};
            word_addr_q <= {ADDR_WIDTH{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            type_q      <= type_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            word_addr_q <= word_addr_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign err_o         = err_q;

    // Bus outputs come from latched values and are zero whenever no request is in flight.
    assign mem_bus.req   = bus_active_s;
    assign mem_bus.addr  = bus_active_s ? word_addr_q : {ADDR_WIDTH{1'b0}};
    assign mem_bus.we    = bus_active_s ? we_q : 1'b0;
    assign mem_bus.be    = bus_active_s ? be_q : 4'b0000;
    assign mem_bus.wdata = bus_active_s ? wdata_q : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit.
// It applies directed vectors from a table, a reset-abort sequence and random accesses.
// Random accesses are checked against a byte-lane reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i;
    logic        data_we_i;
    logic [1:0]  data_type_i;
    logic        data_sign_ext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_req_i      (data_req_i),
        .data_we_i       (data_we_i),
        .data_type_i     (data_type_i),
        .data_sign_ext_i (data_sign_ext_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .stall_o         (stall_o),
        .resp_valid_o    (resp_valid_o),
        .rdata_o         (rdata_o),
        .err_o           (err_o),
        .mem_bus         (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  dtype;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        logic [31:0] mrdata;
        logic        merr;
        logic        noise;
        logic        bus;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h, expected %h", tag, name, act, exp);
        end
    endtask

    // Reference model: each lane is computed from the access size and offset.
    function automatic void ref_model(input logic we, input logic [1:0] dtype, input logic sext,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] mrdata, input logic merr,
                                      output logic bus, output logic [3:0] be,
                                      output logic [31:0] wd, output logic [31:0] rd,
                                      output logic err);
        int size;
        int off;
        logic [31:0] v;
        case (dtype)
            2'd0: size = 1;
            2'd1: size = 2;
            2'd2: size = 4;
            default: size = 0;
        endcase
        off = int'(addr[1:0]);
        be = 4'b0000;
        wd = 32'h0;
        rd = 32'h0;
        if (size == 0 || (off % size) != 0) begin
            bus = 1'b0;
            err = 1'b1;
        end else begin
            bus = 1'b1;
            err = merr;
            for (int j = 0; j < 4; j++) begin
                be[j] = (j >= off) && (j < off + size);
                wd[8*j +: 8] = wdata[8*(j % size) +: 8];
            end
            if (!we && !merr) begin
                v = 32'h0;
                for (int k = 0; k < size; k++) v[8*k +: 8] = mrdata[8*(off+k) +: 8];
                if (sext && v[8*size-1]) begin
                    for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
                end
                rd = v;
            end
        end
    endfunction

    // Run one access. Entered at posedge+1; returns at posedge+1 after one idle cycle.
    // gd = REQ cycles before gnt; rd = WAIT cycles before rvalid.
    task automatic run_access(input string tag, input vec_t v);
        int done_cyc;
        logic in_req;
        done_cyc = v.bus ? (v.gd + v.rd + 3) : 1;
        data_req_i      = 1'b1;
        data_we_i       = v.we;
        data_type_i     = v.dtype;
        data_sign_ext_i = v.sext;
        addr_i          = v.addr;
        wdata_i         = v.wdata;
        for (int c = 0; c <= done_cyc; c++) begin
            @(negedge clk);
            in_req = v.bus && (c >= 1) && (c <= v.gd + 1);
            chk(tag, "stall", {31'd0, stall_o}, {31'd0, (c < done_cyc)});
            chk(tag, "resp_valid", {31'd0, resp_valid_o}, {31'd0, (c == done_cyc)});
            chk(tag, "mem_req", {31'd0, mem_if.req}, {31'd0, in_req});
            chk(tag, "mem_addr", mem_if.addr, in_req ? {v.addr[31:2], 2'b00} : 32'h0);
            chk(tag, "mem_be", {28'd0, mem_if.be}, {28'd0, (in_req ? v.ebe : 4'b0000)});
            chk(tag, "mem_we", {31'd0, mem_if.we}, {31'd0, (in_req ? v.we : 1'b0)});
            chk(tag, "mem_wdata", mem_if.wdata, in_req ? v.ewd : 32'h0);
            if (c == done_cyc) begin
                chk(tag, "rdata", rdata_o, v.erd);
                chk(tag, "err", {31'd0, err_o}, {31'd0, v.eerr});
            end
            mem_if.gnt = v.bus && (c == v.gd + 1);
            if (v.bus && (c == v.gd + v.rd + 2)) begin
                mem_if.rvalid = 1'b1;
                mem_if.rdata  = v.mrdata;
                mem_if.err    = v.merr;
            end else if (v.noise && v.bus && (c == v.gd + 1)) begin
                mem_if.rvalid = 1'b1;
                mem_if.rdata  = ~v.mrdata;
                mem_if.err    = 1'b1;
            end else begin
                mem_if.rvalid = 1'b0;
                mem_if.rdata  = $urandom;
                mem_if.err    = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        data_req_i    = 1'b0;
        mem_if.gnt    = 1'b0;
        mem_if.rvalid = 1'b0;
        mem_if.err    = 1'b0;
        @(negedge clk);
        chk(tag, "idle_stall", {31'd0, stall_o}, 32'd0);
        chk(tag, "idle_req", {31'd0, mem_if.req}, 32'd0);
        chk(tag, "idle_resp", {31'd0, resp_valid_o}, 32'd0);
        chk(tag, "hold_rdata", rdata_o, v.erd);
        chk(tag, "hold_err", {31'd0, err_o}, {31'd0, v.eerr});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];
    vec_t rv;

    initial begin
        rst             = 1'b1;
        data_req_i      = 1'b1;
        data_we_i       = 1'b0;
        data_type_i     = 2'b10;
        data_sign_ext_i = 1'b0;
        addr_i          = 32'h0;
        wdata_i         = 32'h0;
        mem_if.gnt      = 1'b0;
        mem_if.rvalid   = 1'b0;
        mem_if.rdata    = 32'h0;
        mem_if.err      = 1'b0;

        //         we    type  sext  addr          wdata         gd rd mrdata        merr noise bus  be       ewd           erd           eerr
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0000_0000, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_0000, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0000_0000, 32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 0, 1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0000_0000, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0000_0000, 1, 0, 32'h8001_0000, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0000_0000, 0, 2, 32'h1234_7FFF, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h0000_0000, 32'h0000_7FFF, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'hAABB_CC5A, 2, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_010C, 32'hCAFE_F00D, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0000_0000, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_0000, 0, 0, 32'h1122_3344, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_0000, 32'h0000_0033, 1'b0};
        vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_1234, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0000_0000, 5, 2, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};

        // Reset state. data_req_i is held high to show that it is masked.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", "stall", {31'd0, stall_o}, 32'd0);
        chk("reset", "resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("reset", "mem_req", {31'd0, mem_if.req}, 32'd0);
        chk("reset", "rdata", rdata_o, 32'h0);
        chk("reset", "err", {31'd0, err_o}, 32'd0);
        data_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_access($sformatf("vec%0d", i), vecs[i]);

        // Reset in WAIT, followed by a late rvalid. err_o is 1 from the last vector.
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_type_i = 2'd2;
        addr_i      = 32'h0000_0300;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid", "req_in_REQ", {31'd0, mem_if.req}, 32'd1);
        mem_if.gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_if.gnt = 1'b0;
        @(negedge clk);
        chk("rstmid", "stall_in_WAIT", {31'd0, stall_o}, 32'd1);
        chk("rstmid", "err_before", {31'd0, err_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid", "stall", {31'd0, stall_o}, 32'd0);
        chk("rstmid", "mem_req", {31'd0, mem_if.req}, 32'd0);
        chk("rstmid", "err", {31'd0, err_o}, 32'd0);
        chk("rstmid", "rdata", rdata_o, 32'h0);
        data_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = 32'hFFFF_FFFF;
        mem_if.err    = 1'b1;
        @(negedge clk);
        chk("rstmid", "resp_stale0", {31'd0, resp_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        mem_if.rvalid = 1'b0;
        mem_if.err    = 1'b0;
        @(negedge clk);
        chk("rstmid", "resp_stale1", {31'd0, resp_valid_o}, 32'd0);
        chk("rstmid", "stall_after", {31'd0, stall_o}, 32'd0);
        chk("rstmid", "rdata_after", rdata_o, 32'h0);
        chk("rstmid", "err_after", {31'd0, err_o}, 32'd0);
        @(posedge clk);
        #1;

        // Random accesses checked against the reference model.
        for (int n = 0; n < 200; n++) begin
            int t;
            t = $urandom_range(0, 9);
            rv.dtype  = (t < 3) ? 2'd0 : (t < 6) ? 2'd1 : (t < 9) ? 2'd2 : 2'd3;
            rv.we     = 1'($urandom_range(0, 1));
            rv.sext   = 1'($urandom_range(0, 1));
            rv.addr   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                rv.addr[1:0] = (rv.dtype == 2'd2) ? 2'b00 :
                               (rv.dtype == 2'd1) ? {rv.addr[1], 1'b0} : rv.addr[1:0];
            end
            rv.wdata  = $urandom;
            rv.mrdata = $urandom;
            rv.merr   = ($urandom_range(0, 7) == 0);
            rv.noise  = 1'($urandom_range(0, 1));
            rv.gd     = $urandom_range(0, 3);
            rv.rd     = $urandom_range(0, 3);
            ref_model(rv.we, rv.dtype, rv.sext, rv.addr, rv.wdata, rv.mrdata, rv.merr,
                      rv.bus, rv.ebe, rv.ewd, rv.erd, rv.eerr);
            run_access($sformatf("rnd%0d", n), rv);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
